// File: rtl/clock_select_pkg.sv
// Shared types and helpers for the CPU clock-select sequencer.
package clock_select_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    WAIT_BUS,
    SWITCH_SRC,
    SETTLE,
    SWITCH_GRP
  } state_t;

  // Code of the stock CPU clock; also the fallback for out-of-range requests.
  localparam int CODE_STOCK = 0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/clock_select_seq_sync2.sv
// Two-flop synchroniser with a configurable reset level.
module sync2 #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops bring the asynchronous input into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= {WIDTH{RST_VAL}};
      r_sync <= {WIDTH{RST_VAL}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clock_select_seq.sv
// Sequenced CPU clock selection: debounce the request, wait for an idle
// 68000 bus, move the DCS select, let it settle, then move the group mux.
module clock_select_seq
  import clock_select_pkg::*;
#(
  parameter int NUM_GROUPS      = 2,
  parameter int SRC_PER_GROUP   = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 8,
  localparam int NSRC  = NUM_GROUPS * SRC_PER_GROUP,
  localparam int SEL_W = clog2(NSRC),
  localparam int GRP_W = (clog2(NUM_GROUPS) > 1) ? clog2(NUM_GROUPS) : 1
) (
  input  logic             C7M,
  input  logic             RESET,
  input  logic [SEL_W-1:0] SEL_REQ,
  input  logic             CPU_SPEED_SWITCH,
  input  logic             AS_CPU_n,
  input  logic             DTACK_CPU_n,
  output logic [NSRC-1:0]  SRC_SEL,
  output logic [GRP_W-1:0] GRP_SEL,
  output logic [SEL_W-1:0] CUR_SEL,
  output logic             BUSY
);

  localparam int DC_W = clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SC_W = clog2(SETTLE_CYCLES) + 1;
  localparam logic [SRC_PER_GROUP-1:0] SLICE_RST = SRC_PER_GROUP'(1);
  localparam logic [NSRC-1:0]          SRC_RST   = {NUM_GROUPS{SLICE_RST}};

  logic [SEL_W-1:0]         w_sel_s;
  logic                     w_switch_s;
  logic                     w_as_s;
  logic                     w_dtack_s;
  logic [SEL_W-1:0]         w_target;
  logic [1:0]               r_idle_sh;
  logic                     w_bus_idle;
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SEL_W-1:0]         r_cand;
  logic [SEL_W-1:0]         r_cur_sel;
  logic [DC_W-1:0]          r_dcnt;
  logic [SC_W-1:0]          r_scnt;
  logic [NSRC-1:0]          r_src_sel;
  logic [NSRC-1:0]          w_src_nxt;
  logic [GRP_W-1:0]         r_grp_sel;
  logic [GRP_W-1:0]         w_cand_grp;
  logic [SRC_PER_GROUP-1:0] w_cand_onehot;
  logic                     r_busy;
  logic                     w_load_cand;
  logic                     w_dcnt_dec;
  logic                     w_load_src;
  logic                     w_load_scnt;
  logic                     w_scnt_dec;
  logic                     w_load_grp;

  sync2 #(.WIDTH(SEL_W), .RST_VAL(1'b0)) u_sync_sel (
    .i_clk(C7M), .i_rst(RESET), .i_d(SEL_REQ), .o_q(w_sel_s));
  sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_switch (
    .i_clk(C7M), .i_rst(RESET), .i_d(CPU_SPEED_SWITCH), .o_q(w_switch_s));
  sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_as (
    .i_clk(C7M), .i_rst(RESET), .i_d(AS_CPU_n), .o_q(w_as_s));
  sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_dtack (
    .i_clk(C7M), .i_rst(RESET), .i_d(DTACK_CPU_n), .o_q(w_dtack_s));

  // Effective target: the speed switch forces stock, and unknown codes fall back to stock.
  always_comb begin
    w_target = w_switch_s ? SEL_W'(CODE_STOCK) : w_sel_s;
    if (int'(w_target) >= NSRC) w_target = SEL_W'(CODE_STOCK);
  end

  // Bus is idle only after AS and DTACK have both been seen negated on two samples in a row.
  always_ff @(posedge C7M) begin
    if (RESET) r_idle_sh <= 2'b00;
    else       r_idle_sh <= {r_idle_sh[0], w_as_s & w_dtack_s};
  end

  assign w_bus_idle = &r_idle_sh;

  assign w_cand_grp    = GRP_W'(int'(r_cand) / SRC_PER_GROUP);
  assign w_cand_onehot = SRC_PER_GROUP'(1) << (int'(r_cand) % SRC_PER_GROUP);

  // New select vector: only the candidate's group slice is rewritten.
  always_comb begin
    w_src_nxt = r_src_sel;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (g == int'(r_cand) / SRC_PER_GROUP)
        w_src_nxt[g*SRC_PER_GROUP +: SRC_PER_GROUP] = w_cand_onehot;
    end
  end

  // State register.
  always_ff @(posedge C7M) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (w_target != r_cur_sel) w_state_nxt = DEBOUNCE;
      DEBOUNCE: begin
        if (w_target != r_cand)         w_state_nxt = DEBOUNCE;
        else if (w_target == r_cur_sel) w_state_nxt = IDLE;
        else if (r_dcnt == '0)          w_state_nxt = WAIT_BUS;
      end
      WAIT_BUS: begin
        if (w_target != r_cand) w_state_nxt = DEBOUNCE;
        else if (w_bus_idle)    w_state_nxt = SWITCH_SRC;
      end
      SWITCH_SRC: w_state_nxt = SETTLE;
      SETTLE:     if (r_scnt == '0) w_state_nxt = SWITCH_GRP;
      SWITCH_GRP: w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Output/control decode; select registers update on entry to the switch states.
  always_comb begin
    w_load_cand = ((r_state == IDLE) && (w_target != r_cur_sel)) ||
                  (((r_state == DEBOUNCE) || (r_state == WAIT_BUS)) && (w_target != r_cand));
    w_dcnt_dec  = (r_state == DEBOUNCE) && (w_state_nxt == DEBOUNCE) && !w_load_cand;
    w_load_src  = (r_state == WAIT_BUS) && (w_state_nxt == SWITCH_SRC);
    w_load_scnt = (r_state == SWITCH_SRC);
    w_scnt_dec  = (r_state == SETTLE) && (r_scnt != '0);
    w_load_grp  = (r_state == SETTLE) && (w_state_nxt == SWITCH_GRP);
  end

  // Candidate, counters and registered outputs.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      r_cand    <= '0;
      r_dcnt    <= '0;
      r_scnt    <= '0;
      r_src_sel <= SRC_RST;
      r_grp_sel <= '0;
      r_cur_sel <= SEL_W'(CODE_STOCK);
      r_busy    <= 1'b0;
    end else begin
      if (w_load_cand) begin
        r_cand <= w_target;
        r_dcnt <= DC_W'(DEBOUNCE_CYCLES - 1);
      end else if (w_dcnt_dec) begin
        r_dcnt <= r_dcnt - 1'b1;
      end
      if (w_load_scnt)     r_scnt <= SC_W'(SETTLE_CYCLES - 1);
      else if (w_scnt_dec) r_scnt <= r_scnt - 1'b1;
      if (w_load_src) r_src_sel <= w_src_nxt;
      if (w_load_grp) begin
        r_grp_sel <= w_cand_grp;
        r_cur_sel <= r_cand;
      end
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign SRC_SEL = r_src_sel;
  assign GRP_SEL = r_grp_sel;
  assign CUR_SEL = r_cur_sel;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_clock_select_seq.sv
// Directed bench for clock_select_seq with 2 groups x 4 sources, debounce 4, settle 8.
module tb_clock_select_seq;

  logic       C7M;
  logic       RESET;
  logic [2:0] SEL_REQ;
  logic       CPU_SPEED_SWITCH;
  logic       AS_CPU_n;
  logic       DTACK_CPU_n;
  logic [7:0] SRC_SEL;
  logic [0:0] GRP_SEL;
  logic [2:0] CUR_SEL;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  clock_select_seq #(
    .NUM_GROUPS(2), .SRC_PER_GROUP(4), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(8)
  ) dut (
    .C7M(C7M), .RESET(RESET), .SEL_REQ(SEL_REQ), .CPU_SPEED_SWITCH(CPU_SPEED_SWITCH),
    .AS_CPU_n(AS_CPU_n), .DTACK_CPU_n(DTACK_CPU_n),
    .SRC_SEL(SRC_SEL), .GRP_SEL(GRP_SEL), .CUR_SEL(CUR_SEL), .BUSY(BUSY)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge C7M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; SEL_REQ = 3'd0; CPU_SPEED_SWITCH = 1'b0;
    AS_CPU_n = 1'b1; DTACK_CPU_n = 1'b1;
    step(3);
    check("rst_src", 32'(SRC_SEL), 32'h11);
    check("rst_grp", 32'(GRP_SEL), 32'd0);
    check("rst_cur", 32'(CUR_SEL), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    step(5);
    check("idle_busy", 32'(BUSY), 32'd0);

    // Same-group switch 0 -> 2
    SEL_REQ = 3'd2;
    step(2);
    check("sg_busy_e2", 32'(BUSY), 32'd0);
    step(1);
    check("sg_busy_e3", 32'(BUSY), 32'd1);
    step(4);
    check("sg_src_e7", 32'(SRC_SEL), 32'h11);
    step(1);
    check("sg_src_e8", 32'(SRC_SEL), 32'h14);
    check("sg_grp_e8", 32'(GRP_SEL), 32'd0);
    check("sg_cur_e8", 32'(CUR_SEL), 32'd0);
    step(8);
    check("sg_cur_e16", 32'(CUR_SEL), 32'd0);
    step(1);
    check("sg_cur_e17", 32'(CUR_SEL), 32'd2);
    check("sg_grp_e17", 32'(GRP_SEL), 32'd0);
    check("sg_busy_e17", 32'(BUSY), 32'd1);
    step(1);
    check("sg_busy_e18", 32'(BUSY), 32'd0);

    // Cross-group switch 2 -> 6
    SEL_REQ = 3'd6;
    step(8);
    check("xg_src_e8", 32'(SRC_SEL), 32'h44);
    check("xg_grp_e8", 32'(GRP_SEL), 32'd0);
    step(8);
    check("xg_grp_e16", 32'(GRP_SEL), 32'd0);
    step(1);
    check("xg_grp_e17", 32'(GRP_SEL), 32'd1);
    check("xg_cur_e17", 32'(CUR_SEL), 32'd6);
    check("xg_src_e17", 32'(SRC_SEL), 32'h44);
    step(3);
    check("xg_busy_end", 32'(BUSY), 32'd0);

    // Back to code 0, then a 2-cycle glitch to 3
    SEL_REQ = 3'd0;
    step(25);
    check("to0_cur", 32'(CUR_SEL), 32'd0);
    check("to0_src", 32'(SRC_SEL), 32'h41);
    check("to0_grp", 32'(GRP_SEL), 32'd0);
    SEL_REQ = 3'd3;
    step(2);
    SEL_REQ = 3'd0;
    step(2);
    check("gl_busy_mid", 32'(BUSY), 32'd1);
    step(6);
    check("gl_busy_end", 32'(BUSY), 32'd0);
    check("gl_src", 32'(SRC_SEL), 32'h41);
    check("gl_cur", 32'(CUR_SEL), 32'd0);

    // Request 3 replaced by 5 before it commits
    SEL_REQ = 3'd3;
    step(5);
    SEL_REQ = 3'd5;
    step(30);
    check("rq_cur", 32'(CUR_SEL), 32'd5);
    check("rq_grp", 32'(GRP_SEL), 32'd1);
    check("rq_src", 32'(SRC_SEL), 32'h21);
    check("rq_busy", 32'(BUSY), 32'd0);

    // Bus hold-off: AS low for 20 cycles while requesting code 1
    AS_CPU_n = 1'b0;
    step(2);
    SEL_REQ = 3'd1;
    step(18);
    check("bh_src_held", 32'(SRC_SEL), 32'h21);
    check("bh_busy_held", 32'(BUSY), 32'd1);
    check("bh_cur_held", 32'(CUR_SEL), 32'd5);
    AS_CPU_n = 1'b1;
    step(4);
    check("bh_src_f4", 32'(SRC_SEL), 32'h21);
    step(1);
    check("bh_src_f5", 32'(SRC_SEL), 32'h22);
    step(10);
    check("bh_cur", 32'(CUR_SEL), 32'd1);
    check("bh_grp", 32'(GRP_SEL), 32'd0);

    // Speed switch overrides the jumpers
    CPU_SPEED_SWITCH = 1'b1;
    SEL_REQ = 3'd7;
    step(25);
    check("ov_cur", 32'(CUR_SEL), 32'd0);
    check("ov_src", 32'(SRC_SEL), 32'h21);
    check("ov_grp", 32'(GRP_SEL), 32'd0);
    check("ov_busy", 32'(BUSY), 32'd0);

    // Release override, then reset while settling
    CPU_SPEED_SWITCH = 1'b0;
    step(8);
    check("rs_src_e8", 32'(SRC_SEL), 32'h81);
    check("rs_busy_e8", 32'(BUSY), 32'd1);
    step(2);
    RESET = 1'b1;
    step(1);
    check("rs_src", 32'(SRC_SEL), 32'h11);
    check("rs_grp", 32'(GRP_SEL), 32'd0);
    check("rs_cur", 32'(CUR_SEL), 32'd0);
    check("rs_busy", 32'(BUSY), 32'd0);
    step(1);
    RESET = 1'b0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_select_seq.md
# clock_select_seq

Parametrised CPU clock-select sequencer that runs on C7M and drives the one-hot select inputs of a bank of dynamic clock selectors (DCS), plus the final group mux. It replaces direct jumper-to-select decoding with a sequenced change. Requests are synchronised and debounced. A switch is deferred until the 68000 bus is idle. The newly selected DCS is allowed to settle before the group mux moves, so the CPU never sees a runt clock mid-bus-cycle.

## Interface
Parameters:
- NUM_GROUPS, 2: number of DCS instances; power of two, 1..8.
- SRC_PER_GROUP, 4: clock inputs per DCS; power of two, 2..8.
- DEBOUNCE_CYCLES, 16: C7M cycles the request must be stable; ≥1.
- SETTLE_CYCLES, 8: C7M cycles allowed for a DCS output to settle; ≥1.
- Derived: NSRC = NUM_GROUPS*SRC_PER_GROUP; SEL_W = clog2(NSRC); GRP_W = max(1, clog2(NUM_GROUPS)).

Ports:
- C7M  in  1  sole clock, 7.09 MHz.
- RESET  in  1  synchronous, active-high reset.
- SEL_REQ  in  SEL_W  requested clock code (jumpers); asynchronous.
- CPU_SPEED_SWITCH  in  1  1 = force code 0 (stock clock); asynchronous.
- AS_CPU_n  in  1  CPU address strobe; asynchronous.
- DTACK_CPU_n  in  1  CPU DTACK; asynchronous.
- SRC_SEL  out  NSRC  concatenated one-hot selects; group g owns bits [g*SRC_PER_GROUP +: SRC_PER_GROUP].
- GRP_SEL  out  GRP_W  selects which DCS output feeds CLKCPU.
- CUR_SEL  out  SEL_W  code currently in effect.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- All four asynchronous inputs pass through 2-FF synchronisers, with reset value 1 for the _n signals and 0 for the others.
- Target code: target = switch_s ? 0 : SEL_REQ_s. A code ≥ NSRC is treated as 0.
- Decode: grp = code / SRC_PER_GROUP; src = code % SRC_PER_GROUP.
- bus_idle is true when AS_s = 1 and DTACK_s = 1 on two consecutive sampled cycles, tracked by a 2-bit shift register.

States:
- IDLE: if target ≠ CUR_SEL, latch cand = target, load dcnt = DEBOUNCE_CYCLES-1, and go to DEBOUNCE.
- DEBOUNCE:
  - If target ≠ cand, reload cand and dcnt and stay (restart).
  - If target = CUR_SEL, go to IDLE (request withdrawn).
  - If dcnt = 0, go to WAIT_BUS; otherwise decrement dcnt.
- WAIT_BUS:
  - If target ≠ cand, return to DEBOUNCE with the new cand.
  - Else if bus_idle, go to SWITCH_SRC.
  - There is no timeout.
- SWITCH_SRC (1 cycle):
  - Write the one-hot for src(cand) into the slice of group grp(cand).
  - Other slices keep their value.
  - Load scnt = SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: decrement scnt. At 0, go to SWITCH_GRP.
- SWITCH_GRP (1 cycle): GRP_SEL ← grp(cand), CUR_SEL ← cand, go to IDLE. This happens even when the group is unchanged.
- Once in SWITCH_SRC, the change is committed. Target changes are ignored until IDLE, which then re-evaluates.

Reset values:
- SRC_SEL: each slice = one-hot bit 0 (…0001 per group).
- GRP_SEL = 0, CUR_SEL = 0, BUSY = 0, state = IDLE.
- Synchronisers are at their reset values.

Reset asserted in any state forces the reset values on the next C7M edge. The select outputs therefore return to code 0 without sequencing; this is acceptable because the CPU is held in reset.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- With the bus already idle and the request stable, SRC_SEL changes 3 + DEBOUNCE_CYCLES + 1 cycles after the SEL_REQ edge. This breaks down as 2 sync cycles, 1 IDLE cycle, DEBOUNCE_CYCLES, and 1 WAIT_BUS cycle.
- GRP_SEL and CUR_SEL change SETTLE_CYCLES + 1 cycles after SRC_SEL.
- BUSY rises the cycle after IDLE detects a mismatch. It falls the cycle after SWITCH_GRP.
- A bus cycle in progress holds off the switch until AS has been sampled high for 2 cycles with DTACK also high.
- At most one SRC_SEL slice changes per switch, and it changes in exactly one cycle.
- GRP_SEL never changes in the same cycle as SRC_SEL.

## Structure
- Package clock_select_pkg holds:
  - the state enum (IDLE, DEBOUNCE, WAIT_BUS, SWITCH_SRC, SETTLE, SWITCH_GRP);
  - a clog2 function;
  - the constant CODE_STOCK = 0.
- One sub-module, sync2, is a 2-FF synchroniser with a reset-value parameter. It is instantiated four times.
- The counters (dcnt, scnt) are sized to clog2 of their parameter plus 1. Both live inline in the FSM.

## Test plan
All scenarios use NUM_GROUPS=2, SRC_PER_GROUP=4, DEBOUNCE_CYCLES=4, SETTLE_CYCLES=8.
- Reset: hold RESET for 3 cycles → SRC_SEL=8'b0001_0001, GRP_SEL=0, CUR_SEL=0, BUSY=0.
- Same-group switch: bus idle, SEL_REQ 0→2 → SRC_SEL=0001_0100 at cycle 8 after the edge; GRP_SEL=0 and CUR_SEL=2 at cycle 17; BUSY low at cycle 18.
- Cross-group switch: SEL_REQ 2→6 → upper slice becomes 0100 while GRP_SEL is still 0; 9 cycles later GRP_SEL=1, CUR_SEL=6; lower slice stays 0100.
- Debounce: SEL_REQ toggles 0→3→0 with a 2-cycle glitch → no output change and BUSY returns low. Also cover a 3→5 change mid-DEBOUNCE → the final CUR_SEL is 5.
- Bus hold-off: AS_CPU_n held low for 20 cycles during a request → SRC_SEL unchanged until 2 sampled-idle cycles after AS/DTACK rise.
- Override and reset mid-op: CPU_SPEED_SWITCH=1 with SEL_REQ=7 → CUR_SEL goes to 0. Separately, RESET asserted in SETTLE → reset values on the next edge.
